pdm_mic_decimator: RTL

//  Front end of the audio path, directly upstream of the sample recorder.

---
 rtl/pdm_mic_decimator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pdm_mic_decimator.sv
// PDM microphone front end: generates the mic clock, synchronizes the 1-bit stream,
// and decimates each DECIM-bit window by ones-count into 8-bit offset-binary PCM.
module pdm_mic_decimator #(
  parameter int CLK_DIV    = 32,
  parameter int DECIM      = 256,
  parameter int WARMUP_WIN = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       mic_data_in,
  output logic       mic_clk_out,
  output logic [7:0] audio_out,
  output logic       audio_valid_out
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DECIM);
  localparam int ACC_W = BIT_W + 1;
  localparam int SHIFT = BIT_W - 8;
  localparam int WIN_W = (WARMUP_WIN > 0) ? $clog2(WARMUP_WIN + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DECIM - 1);
  localparam logic [ACC_W-1:0] FULL     = ACC_W'(DECIM);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WARMUP_WIN);

  typedef enum logic {
    WARMUP,
    RUN
  } state_t;

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] total;
  logic [7:0]       pcm;
  logic             sync_meta;
  logic             mic_sync;
  logic             strobe;
  logic             window_done;
  logic             emit;
  state_t           state;
  state_t           state_next;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_cnt_next;

  // Divider and mic clock: high for the second half of each div_cnt period.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt     <= '0;
      mic_clk_out <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (div_cnt == DIV_HALF) begin
        mic_clk_out <= 1'b1;
      end else if (div_cnt == DIV_LAST) begin
        mic_clk_out <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_meta <= 1'b0;
      mic_sync  <= 1'b0;
    end else begin
      sync_meta <= mic_data_in;
      mic_sync  <= sync_meta;
    end
  end

  // Data is sampled on the mic clock falling edge, half a period after the mic launches it.
  assign strobe      = (div_cnt == DIV_LAST);
  assign window_done = strobe && (bit_cnt == BIT_LAST);
  assign total       = acc + {{BIT_W{1'b0}}, mic_sync};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (strobe) begin
      if (window_done) begin
        acc     <= '0;
        bit_cnt <= '0;
      end else begin
        acc     <= total;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // An all-ones window would need 9 bits after shifting, so only that case saturates.
  always_comb begin
    pcm = total[SHIFT +: 8];
    if (total == FULL) begin
      pcm = 8'hFF;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= WARMUP;
      win_cnt <= '0;
    end else begin
      state   <= state_next;
      win_cnt <= win_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    emit         = 1'b0;
    if (state == WARMUP) begin
      if (window_done) begin
        if (win_cnt == WIN_LAST) begin
          state_next = RUN;
          emit       = 1'b1;
        end else begin
          win_cnt_next = win_cnt + 1'b1;
        end
      end
    end else begin
      emit = window_done;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      audio_out       <= 8'd128;
      audio_valid_out <= 1'b0;
    end else begin
      audio_valid_out <= emit;
      if (emit) begin
        audio_out <= pcm;
      end
    end
  end

endmodule
